imem_fetch: RTL and testbench
=============================

IMEM_FETCH -- requirements
Module: imem_fetch

Interface
REQ-001 Parameter TIMEOUT, default 15: maximum cycles spent in WAIT before a fetch fault is raised.
REQ-002 clk  in  1  single clock; all state SHALL change only on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset.
REQ-004 pc  in  32  fetch address driven by the datapath PC register.
REQ-005 advance  in  1  datapath retires the current instruction this cycle.
REQ-006 instr  out  32  instruction word delivered to the datapath.
REQ-007 instr_valid  out  1  instr holds the word fetched from the current pc.
REQ-008 stall  out  1  datapath SHALL hold its PC register while this is high.
REQ-009 mem_req  out  1  request to instruction memory.
REQ-010 mem_addr  out  32  word-aligned request address.
REQ-011 mem_gnt  in  1  memory accepts the request this cycle.
REQ-012 mem_rvalid  in  1  mem_rdata is valid this cycle.
REQ-013 mem_rdata  in  32  returned instruction word.
REQ-014 fetch_err  out  1  sticky fault: misaligned pc or response timeout.

Function
REQ-015 FSM states SHALL be IDLE, REQ, WAIT, VALID, ERR; exactly one state active.
REQ-016 IDLE: if pc[1:0]!=0 -> ERR; else if tag_valid and pc==tag -> VALID (no memory access); else capture {pc[31:2],2'b00} into mem_addr -> REQ.
REQ-017 REQ: mem_req=1, mem_addr stable until grant; on mem_gnt -> WAIT with wait counter cleared to 0.
REQ-018 mem_req SHALL be 0 in every state other than REQ; mem_addr SHALL hold its last value outside REQ.
REQ-019 WAIT: on mem_rvalid, instr<=mem_rdata, tag<=mem_addr, tag_valid<=1 -> VALID.
REQ-020 WAIT without mem_rvalid: counter +1 per cycle; when counter==TIMEOUT and no mem_rvalid -> ERR.
REQ-021 mem_rvalid in the same cycle counter reaches TIMEOUT SHALL win: capture data, go to VALID.
REQ-022 mem_rvalid in IDLE, REQ, VALID or ERR SHALL be ignored; mem_rvalid in the mem_gnt cycle SHALL be ignored (response arrives at least 1 cycle after grant).
REQ-023 VALID: instr_valid=1, stall=0; on advance -> IDLE, else remain VALID with instr unchanged.
REQ-024 stall SHALL equal 1 in every state except VALID.
REQ-025 instr SHALL change only on a WAIT capture or reset.
REQ-026 ERR: fetch_err=1, stall=1, instr_valid=0, mem_req=0; state held until reset.
REQ-027 Minimum latency: IDLE->REQ->WAIT->VALID; with gnt in the first REQ cycle and rvalid in the first WAIT cycle, instr_valid rises 3 cycles after leaving VALID.
REQ-028 Tag hit (pc unchanged after advance, e.g. branch-to-self): VALID SHALL reassert exactly 1 cycle after IDLE with no mem_req.
REQ-029 Counter SHALL be wide enough for TIMEOUT and SHALL never wrap.

Reset
REQ-030 When reset=1 at a clock edge, the next state SHALL be IDLE regardless of the current state, including REQ, WAIT and ERR.
REQ-031 Reset values: instr=0, instr_valid=0, stall=1, mem_req=0, mem_addr=0, fetch_err=0, tag=0, tag_valid=0, counter=0.
REQ-032 Instruction memory shares reset; no response from before reset SHALL be accepted after reset.

Verification
REQ-033 Reset, pc=0x0, gnt in the first REQ cycle, rvalid with 0xE3A01005 one cycle later -> mem_addr=0x0; instr=0xE3A01005 and instr_valid=1 on cycle 3.
REQ-034 pc=0x10, gnt held low 4 cycles -> mem_req=1 with mem_addr=0x10 stable all 4 cycles; single WAIT entry after gnt.
REQ-035 VALID, advance=1, pc unchanged at 0x10 -> next cycle IDLE, following cycle VALID with instr unchanged, mem_req never high.
REQ-036 pc=0x6 in IDLE -> fetch_err=1 and stall=1 next cycle; holds for 20 cycles until reset, then all outputs return to reset values.
REQ-037 TIMEOUT=15, no rvalid after gnt -> ERR entered after the 15th WAIT cycle; repeat with rvalid in the same cycle as the 15th count -> VALID, fetch_err=0.
REQ-038 Reset asserted mid-WAIT, rvalid pulsed the next cycle -> pulse ignored, state IDLE, instr=0, instr_valid=0.

Source files
------------

// File: rtl/imem_fetch.sv
// imem_fetch -- single-outstanding instruction fetch unit.
//
// Fetches the word at pc from instruction memory with a req/gnt request phase
// and an rvalid response phase. The datapath is stalled until the word is
// available. A one-entry tag (the last fetched address) lets a repeated fetch
// of the same pc, for example a branch-to-self, complete without a memory
// access. A misaligned pc, or a response that has not arrived within TIMEOUT
// cycles of the grant, parks the unit in a sticky error state until reset.
//
// Ports:
//   clk, reset         clock; synchronous active-high reset
//   pc, advance        datapath fetch address; current instruction retires
//   instr, instr_valid fetched word; it belongs to the current pc
//   stall              datapath must hold its PC while high
//   mem_req, mem_addr  memory request and word-aligned address
//   mem_gnt            memory accepts the request
//   mem_rvalid         mem_rdata carries the response this cycle
//   mem_rdata          response data
//   fetch_err          sticky fault flag (misaligned pc or timeout)
module imem_fetch #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc,
  input  logic        advance,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic        stall,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        fetch_err
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_REQ   = 3'd1;
  localparam logic [2:0] S_WAIT  = 3'd2;
  localparam logic [2:0] S_VALID = 3'd3;
  localparam logic [2:0] S_ERR   = 3'd4;

  // The counter has to hold TIMEOUT itself, which is the value it reaches on
  // the last wait cycle. It never counts further, because the FSM leaves WAIT.
  localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   instr_q, instr_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   tag_q, tag_d;
  logic          tag_valid_q, tag_valid_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    instr_d     = instr_q;
    addr_d      = addr_q;
    tag_d       = tag_q;
    tag_valid_d = tag_valid_q;
    case (state_q)
      S_IDLE: begin
        if (pc[1:0] != 2'b00) begin
          state_d = S_ERR;
        end else if (tag_valid_q && (pc == tag_q)) begin
          state_d = S_VALID;
        end else begin
          addr_d  = {pc[31:2], 2'b00};
          state_d = S_REQ;
        end
      end
      // A response is never expected during the grant cycle, so mem_rvalid is
      // ignored here.
      S_REQ: begin
        if (mem_gnt) begin
          cnt_d   = '0;
          state_d = S_WAIT;
        end
      end
      // A response in the last counted cycle takes priority over the timeout.
      S_WAIT: begin
        if (mem_rvalid) begin
          instr_d     = mem_rdata;
          tag_d       = addr_q;
          tag_valid_d = 1'b1;
          state_d     = S_VALID;
        end else begin
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CNT_LAST) state_d = S_ERR;
        end
      end
      S_VALID: begin
        if (advance) state_d = S_IDLE;
      end
      S_ERR:   state_d = S_ERR;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      instr_q     <= '0;
      addr_q      <= '0;
      tag_q       <= '0;
      tag_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      instr_q     <= instr_d;
      addr_q      <= addr_d;
      tag_q       <= tag_d;
      tag_valid_q <= tag_valid_d;
    end
  end

  assign instr       = instr_q;
  assign mem_addr    = addr_q;
  assign instr_valid = (state_q == S_VALID);
  assign stall       = (state_q != S_VALID);
  assign mem_req     = (state_q == S_REQ);
  assign fetch_err   = (state_q == S_ERR);

endmodule

// File: tb/tb_imem_fetch.sv
// Directed bench for imem_fetch: a vector table for the main fetch and hit
// flow, plus hand-written sequences for timeout, the response-wins race and
// reset during WAIT.
module tb_imem_fetch;

  logic        clk = 1'b0;
  logic        reset, advance, mem_gnt, mem_rvalid;
  logic [31:0] pc, mem_rdata;
  logic [31:0] instr, mem_addr;
  logic        instr_valid, stall, mem_req, fetch_err;

  int n_cmp = 0;
  int n_bad = 0;

  imem_fetch #(.TIMEOUT(15)) dut (
    .clk(clk), .reset(reset), .pc(pc), .advance(advance),
    .instr(instr), .instr_valid(instr_valid), .stall(stall),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_gnt(mem_gnt),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst;
    logic [31:0] pc;
    logic        adv, gnt, rv;
    logic [31:0] rdata;
    logic [31:0] e_instr;
    logic        e_iv, e_stall, e_req;
    logic [31:0] e_addr;
    logic        e_err;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(logic rst, logic [31:0] p, logic adv, logic gnt,
                              logic rv, logic [31:0] rd, logic [31:0] ei,
                              logic eiv, logic est, logic erq,
                              logic [31:0] ea, logic eer);
    vec_t v;
    v.rst = rst; v.pc = p; v.adv = adv; v.gnt = gnt; v.rv = rv; v.rdata = rd;
    v.e_instr = ei; v.e_iv = eiv; v.e_stall = est; v.e_req = erq;
    v.e_addr = ea; v.e_err = eer;
    return v;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic check_out(string tg, logic [31:0] ei, logic eiv, logic est,
                           logic erq, logic [31:0] ea, logic eer);
    chk($sformatf("%s.instr", tg), instr, ei);
    chk($sformatf("%s.instr_valid", tg), {31'b0, instr_valid}, {31'b0, eiv});
    chk($sformatf("%s.stall", tg), {31'b0, stall}, {31'b0, est});
    chk($sformatf("%s.mem_req", tg), {31'b0, mem_req}, {31'b0, erq});
    chk($sformatf("%s.mem_addr", tg), mem_addr, ea);
    chk($sformatf("%s.fetch_err", tg), {31'b0, fetch_err}, {31'b0, eer});
  endtask

  task automatic drive(logic rst, logic [31:0] p, logic adv, logic gnt,
                       logic rv, logic [31:0] rd);
    reset = rst; pc = p; advance = adv; mem_gnt = gnt;
    mem_rvalid = rv; mem_rdata = rd;
  endtask

  // Inputs are applied just after a rising edge; outputs are sampled 1 time
  // unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_rows(int lo, int hi);
    for (int i = lo; i <= hi; i++) begin
      drive(tbl[i].rst, tbl[i].pc, tbl[i].adv, tbl[i].gnt, tbl[i].rv, tbl[i].rdata);
      tick();
      check_out($sformatf("row%0d", i), tbl[i].e_instr, tbl[i].e_iv,
                tbl[i].e_stall, tbl[i].e_req, tbl[i].e_addr, tbl[i].e_err);
    end
  endtask

  initial begin
    drive(1'b1, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0);

    //                rst pc      adv gnt rv  rdata         instr         iv st rq addr   err
    tbl.push_back(mk(1, 32'h00, 0, 0, 0, 32'h0,        32'h0,        0, 1, 0, 32'h00, 0)); // 0 reset
    tbl.push_back(mk(0, 32'h00, 0, 0, 0, 32'h0,        32'h0,        0, 1, 1, 32'h00, 0)); // 1 IDLE->REQ
    tbl.push_back(mk(0, 32'h00, 0, 1, 1, 32'hDEADBEEF, 32'h0,        0, 1, 0, 32'h00, 0)); // 2 gnt, rv ignored
    tbl.push_back(mk(0, 32'h00, 0, 0, 1, 32'hE3A01005, 32'hE3A01005, 1, 0, 0, 32'h00, 0)); // 3 VALID on cycle 3
    tbl.push_back(mk(0, 32'h00, 0, 0, 1, 32'h11111111, 32'hE3A01005, 1, 0, 0, 32'h00, 0)); // 4 rv in VALID ignored
    tbl.push_back(mk(0, 32'h10, 1, 0, 0, 32'h0,        32'hE3A01005, 0, 1, 0, 32'h00, 0)); // 5 advance -> IDLE
    tbl.push_back(mk(0, 32'h10, 0, 0, 0, 32'h0,        32'hE3A01005, 0, 1, 1, 32'h10, 0)); // 6 miss -> REQ
    for (int k = 0; k < 4; k++)                                                            // 7-10 gnt low x4
      tbl.push_back(mk(0, 32'h10, 0, 0, 1, 32'h22222222, 32'hE3A01005, 0, 1, 1, 32'h10, 0));
    tbl.push_back(mk(0, 32'h10, 0, 1, 0, 32'h0,        32'hE3A01005, 0, 1, 0, 32'h10, 0)); // 11 gnt -> WAIT
    tbl.push_back(mk(0, 32'h10, 0, 1, 0, 32'h0,        32'hE3A01005, 0, 1, 0, 32'h10, 0)); // 12 still WAIT
    tbl.push_back(mk(0, 32'h10, 0, 0, 1, 32'h12345678, 32'h12345678, 1, 0, 0, 32'h10, 0)); // 13 capture
    tbl.push_back(mk(0, 32'h10, 1, 0, 0, 32'h0,        32'h12345678, 0, 1, 0, 32'h10, 0)); // 14 advance, same pc
    tbl.push_back(mk(0, 32'h10, 0, 0, 0, 32'h0,        32'h12345678, 1, 0, 0, 32'h10, 0)); // 15 tag hit
    tbl.push_back(mk(0, 32'h10, 0, 0, 0, 32'h0,        32'h12345678, 1, 0, 0, 32'h10, 0)); // 16 hold VALID
    tbl.push_back(mk(0, 32'h06, 1, 0, 0, 32'h0,        32'h12345678, 0, 1, 0, 32'h10, 0)); // 17 -> IDLE
    tbl.push_back(mk(0, 32'h06, 0, 0, 0, 32'h0,        32'h12345678, 0, 1, 0, 32'h10, 1)); // 18 misaligned -> ERR
    tbl.push_back(mk(1, 32'h10, 0, 0, 0, 32'h0,        32'h0,        0, 1, 0, 32'h00, 0)); // 19 reset out of ERR
    tbl.push_back(mk(0, 32'h10, 0, 0, 0, 32'h0,        32'h0,        0, 1, 1, 32'h10, 0)); // 20 tag cleared -> REQ

    run_rows(0, 18);

    // ERR is sticky whatever the other inputs do.
    for (int i = 0; i < 20; i++) begin
      drive(1'b0, 32'h06, i[0], i[1], i[2], 32'hA5A5A5A5);
      tick();
      check_out($sformatf("errhold%0d", i), 32'h12345678, 1'b0, 1'b1, 1'b0, 32'h10, 1'b1);
    end

    run_rows(19, 20);

    // Timeout: 14 silent WAIT cycles stay in WAIT, the 15th goes to ERR.
    drive(1'b1, 32'h20, 0, 0, 0, 32'h0); tick();
    drive(1'b0, 32'h20, 0, 0, 0, 32'h0); tick();
    drive(1'b0, 32'h20, 0, 1, 0, 32'h0); tick();
    check_out("to_wait0", 32'h0, 0, 1, 0, 32'h20, 0);
    for (int i = 1; i <= 14; i++) begin
      drive(1'b0, 32'h20, 0, 0, 0, 32'h0); tick();
    end
    check_out("to_wait14", 32'h0, 0, 1, 0, 32'h20, 0);
    tick();
    check_out("to_err", 32'h0, 0, 1, 0, 32'h20, 1);

    // A response in the 15th WAIT cycle takes priority over the timeout.
    drive(1'b1, 32'h20, 0, 0, 0, 32'h0); tick();
    drive(1'b0, 32'h20, 0, 0, 0, 32'h0); tick();
    drive(1'b0, 32'h20, 0, 1, 0, 32'h0); tick();
    for (int i = 1; i <= 14; i++) begin
      drive(1'b0, 32'h20, 0, 0, 0, 32'h0); tick();
    end
    drive(1'b0, 32'h20, 0, 0, 1, 32'hCAFEF00D); tick();
    check_out("race_valid", 32'hCAFEF00D, 1, 0, 0, 32'h20, 0);
    drive(1'b0, 32'h20, 0, 0, 0, 32'h0); tick();
    check_out("race_hold", 32'hCAFEF00D, 1, 0, 0, 32'h20, 0);

    // Reset during WAIT; a late response must be dropped.
    drive(1'b1, 32'h30, 0, 0, 0, 32'h0); tick();
    drive(1'b0, 32'h30, 0, 0, 0, 32'h0); tick();
    drive(1'b0, 32'h30, 0, 1, 0, 32'h0); tick();
    drive(1'b0, 32'h30, 0, 0, 0, 32'h0); tick();
    check_out("rw_wait", 32'h0, 0, 1, 0, 32'h30, 0);
    drive(1'b1, 32'h30, 0, 0, 0, 32'h0); tick();
    check_out("rw_reset", 32'h0, 0, 1, 0, 32'h0, 0);
    drive(1'b1, 32'h30, 0, 0, 1, 32'h55555555); tick();
    check_out("rw_pulse", 32'h0, 0, 1, 0, 32'h0, 0);
    drive(1'b0, 32'h30, 0, 0, 1, 32'h66666666); tick();
    check_out("rw_req", 32'h0, 0, 1, 1, 32'h30, 0);
    drive(1'b0, 32'h30, 0, 1, 1, 32'h66666666); tick();
    check_out("rw_gnt", 32'h0, 0, 1, 0, 32'h30, 0);
    drive(1'b0, 32'h30, 0, 0, 1, 32'h77777777); tick();
    check_out("rw_valid", 32'h77777777, 1, 0, 0, 32'h30, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
